// File: rtl/axi4_lite_sram_slave_if.sv
// AXI4-Lite bus bundle between a master (IFU/LSU side)
// and the SRAM responder.
interface axi4_lite_sram_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int MASK_WIDTH = DATA_WIDTH / 8;

  logic                  pAXI4S_ar_valid;
  logic [ADDR_WIDTH-1:0] pAXI4S_ar_bits_addr;
  logic                  pAXI4S_ar_ready;
  logic                  pAXI4S_r_valid;
  logic [DATA_WIDTH-1:0] pAXI4S_r_bits_data;
  logic [1:0]            pAXI4S_r_bits_resp;
  logic                  pAXI4S_r_ready;
  logic                  pAXI4S_aw_valid;
  logic [ADDR_WIDTH-1:0] pAXI4S_aw_bits_addr;
  logic                  pAXI4S_aw_ready;
  logic                  pAXI4S_w_valid;
  logic [DATA_WIDTH-1:0] pAXI4S_w_bits_data;
  logic [MASK_WIDTH-1:0] pAXI4S_w_bits_strb;
  logic                  pAXI4S_w_ready;
  logic                  pAXI4S_b_valid;
  logic [1:0]            pAXI4S_b_bits_resp;
  logic                  pAXI4S_b_ready;

  modport master (
    output pAXI4S_ar_valid,
    output pAXI4S_ar_bits_addr,
    input  pAXI4S_ar_ready,
    input  pAXI4S_r_valid,
    input  pAXI4S_r_bits_data,
    input  pAXI4S_r_bits_resp,
    output pAXI4S_r_ready,
    output pAXI4S_aw_valid,
    output pAXI4S_aw_bits_addr,
    input  pAXI4S_aw_ready,
    output pAXI4S_w_valid,
    output pAXI4S_w_bits_data,
    output pAXI4S_w_bits_strb,
    input  pAXI4S_w_ready,
    input  pAXI4S_b_valid,
    input  pAXI4S_b_bits_resp,
    output pAXI4S_b_ready
  );

  modport slave (
    input  pAXI4S_ar_valid,
    input  pAXI4S_ar_bits_addr,
    output pAXI4S_ar_ready,
    output pAXI4S_r_valid,
    output pAXI4S_r_bits_data,
    output pAXI4S_r_bits_resp,
    input  pAXI4S_r_ready,
    input  pAXI4S_aw_valid,
    input  pAXI4S_aw_bits_addr,
    output pAXI4S_aw_ready,
    input  pAXI4S_w_valid,
    input  pAXI4S_w_bits_data,
    input  pAXI4S_w_bits_strb,
    output pAXI4S_w_ready,
    output pAXI4S_b_valid,
    output pAXI4S_b_bits_resp,
    input  pAXI4S_b_ready
  );
endinterface

// File: rtl/axi4_lite_sram_slave.sv
// AXI4-Lite responder over a word-addressed on-chip SRAM.
// Independent read and write engines, one txn in flight each.
module axi4_lite_sram_slave #(
  parameter int                  ADDR_WIDTH = 32,
  parameter int                  DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 32'h8000_0000,
  parameter int                  DEPTH_LOG2 = 10,
  parameter int                  RD_LATENCY = 1
) (
  input logic                  iClock,
  input logic                  iReset,
  axi4_lite_sram_slave_if.slave s_axi
);
  localparam int MASK_WIDTH = DATA_WIDTH / 8;
  localparam int WORDS = 1 << DEPTH_LOG2;
  localparam int CNT_W =
    (RD_LATENCY > 2) ? $clog2(RD_LATENCY) : 1;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_WAIT,
    RD_RESP
  } rd_state_e;

  typedef enum logic {
    WR_IDLE,
    WR_RESP
  } wr_state_e;

  function automatic logic in_range(
    input logic [ADDR_WIDTH-1:0] a
  );
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return (a >= BASE_ADDR) &&
           ((off >> (DEPTH_LOG2 + 2)) == '0);
  endfunction

  function automatic logic [DEPTH_LOG2-1:0] to_index(
    input logic [ADDR_WIDTH-1:0] a
  );
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return DEPTH_LOG2'(off >> 2);
  endfunction

  logic [DATA_WIDTH-1:0] mem [WORDS];

  rd_state_e             rd_state_q, rd_state_d;
  logic                  ar_ready_q, ar_ready_d;
  logic                  r_valid_q, r_valid_d;
  logic [DATA_WIDTH-1:0] r_data_q, r_data_d;
  logic [1:0]            r_resp_q, r_resp_d;
  logic [CNT_W-1:0]      rd_cnt_q, rd_cnt_d;
  logic [ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
  logic                  rd_sample;
  logic [ADDR_WIDTH-1:0] rd_addr;

  wr_state_e             wr_state_q, wr_state_d;
  logic                  aw_ready_q, aw_ready_d;
  logic                  w_ready_q, w_ready_d;
  logic                  b_valid_q, b_valid_d;
  logic [1:0]            b_resp_q, b_resp_d;
  logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic [MASK_WIDTH-1:0] w_strb_q, w_strb_d;
  logic                  aw_hs, w_hs;
  logic                  wr_commit;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [MASK_WIDTH-1:0] wr_strb;
  logic                  mem_we;

  always_comb begin
    rd_state_d = rd_state_q;
    ar_ready_d = ar_ready_q;
    r_valid_d  = r_valid_q;
    r_data_d   = r_data_q;
    r_resp_d   = r_resp_q;
    rd_cnt_d   = rd_cnt_q;
    ar_addr_d  = ar_addr_q;
    rd_sample  = 1'b0;
    rd_addr    = ar_addr_q;
    unique case (rd_state_q)
      RD_IDLE: begin
        if (s_axi.pAXI4S_ar_valid && ar_ready_q) begin
          ar_ready_d = 1'b0;
          ar_addr_d  = s_axi.pAXI4S_ar_bits_addr;
          rd_cnt_d   = '0;
          if (RD_LATENCY == 1) begin
            rd_sample  = 1'b1;
            rd_addr    = s_axi.pAXI4S_ar_bits_addr;
            rd_state_d = RD_RESP;
          end else begin
            rd_state_d = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (rd_cnt_q == CNT_W'(RD_LATENCY - 2)) begin
          rd_sample  = 1'b1;
          rd_cnt_d   = '0;
          rd_state_d = RD_RESP;
        end else begin
          rd_cnt_d = rd_cnt_q + 1'b1;
        end
      end
      RD_RESP: begin
        if (s_axi.pAXI4S_r_ready) begin
          r_valid_d  = 1'b0;
          ar_ready_d = 1'b1;
          rd_state_d = RD_IDLE;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
    // A same-edge write commit is not yet visible here.
    if (rd_sample) begin
      r_valid_d = 1'b1;
      if (in_range(rd_addr)) begin
        r_data_d = mem[to_index(rd_addr)];
        r_resp_d = RESP_OKAY;
      end else begin
        r_data_d = '0;
        r_resp_d = RESP_SLVERR;
      end
    end
  end

  assign aw_hs = s_axi.pAXI4S_aw_valid && aw_ready_q;
  assign w_hs  = s_axi.pAXI4S_w_valid && w_ready_q;

  // A low ready in WR_IDLE means that channel is captured.
  assign wr_addr = aw_ready_q ?
    s_axi.pAXI4S_aw_bits_addr : aw_addr_q;
  assign wr_data = w_ready_q ?
    s_axi.pAXI4S_w_bits_data : w_data_q;
  assign wr_strb = w_ready_q ?
    s_axi.pAXI4S_w_bits_strb : w_strb_q;

  always_comb begin
    wr_state_d = wr_state_q;
    aw_ready_d = aw_ready_q;
    w_ready_d  = w_ready_q;
    b_valid_d  = b_valid_q;
    b_resp_d   = b_resp_q;
    aw_addr_d  = aw_addr_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    wr_commit  = 1'b0;
    unique case (wr_state_q)
      WR_IDLE: begin
        if (aw_hs) begin
          aw_ready_d = 1'b0;
          aw_addr_d  = s_axi.pAXI4S_aw_bits_addr;
        end
        if (w_hs) begin
          w_ready_d = 1'b0;
          w_data_d  = s_axi.pAXI4S_w_bits_data;
          w_strb_d  = s_axi.pAXI4S_w_bits_strb;
        end
        if ((aw_hs || !aw_ready_q) &&
            (w_hs || !w_ready_q)) begin
          wr_commit  = 1'b1;
          aw_ready_d = 1'b0;
          w_ready_d  = 1'b0;
          b_valid_d  = 1'b1;
          b_resp_d   = in_range(wr_addr) ?
                       RESP_OKAY : RESP_SLVERR;
          wr_state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        if (s_axi.pAXI4S_b_ready) begin
          b_valid_d  = 1'b0;
          aw_ready_d = 1'b1;
          w_ready_d  = 1'b1;
          wr_state_d = WR_IDLE;
        end
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  assign mem_we = wr_commit && iReset && in_range(wr_addr);

  always_ff @(posedge iClock) begin
    if (mem_we) begin
      for (int i = 0; i < MASK_WIDTH; i++) begin
        if (wr_strb[i]) begin
          mem[to_index(wr_addr)][8*i +: 8] <=
            wr_data[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge iClock) begin
    if (!iReset) begin
      rd_state_q <= RD_IDLE;
      ar_ready_q <= 1'b1;
      r_valid_q  <= 1'b0;
      r_data_q   <= '0;
      r_resp_q   <= RESP_OKAY;
      rd_cnt_q   <= '0;
      ar_addr_q  <= '0;
      wr_state_q <= WR_IDLE;
      aw_ready_q <= 1'b1;
      w_ready_q  <= 1'b1;
      b_valid_q  <= 1'b0;
      b_resp_q   <= RESP_OKAY;
      aw_addr_q  <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      ar_ready_q <= ar_ready_d;
      r_valid_q  <= r_valid_d;
      r_data_q   <= r_data_d;
      r_resp_q   <= r_resp_d;
      rd_cnt_q   <= rd_cnt_d;
      ar_addr_q  <= ar_addr_d;
      wr_state_q <= wr_state_d;
      aw_ready_q <= aw_ready_d;
      w_ready_q  <= w_ready_d;
      b_valid_q  <= b_valid_d;
      b_resp_q   <= b_resp_d;
      aw_addr_q  <= aw_addr_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
    end
  end

  assign s_axi.pAXI4S_ar_ready    = ar_ready_q;
  assign s_axi.pAXI4S_r_valid     = r_valid_q;
  assign s_axi.pAXI4S_r_bits_data = r_data_q;
  assign s_axi.pAXI4S_r_bits_resp = r_resp_q;
  assign s_axi.pAXI4S_aw_ready    = aw_ready_q;
  assign s_axi.pAXI4S_w_ready     = w_ready_q;
  assign s_axi.pAXI4S_b_valid     = b_valid_q;
  assign s_axi.pAXI4S_b_bits_resp = b_resp_q;
endmodule

// File: tb/tb_axi4_lite_sram_slave.sv
// Directed bench for the AXI4-Lite SRAM responder.
// Expected responses are queued at issue, checked by a monitor.
module tb_axi4_lite_sram_slave;
  localparam int RDL = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] rq_data [$];
  logic [1:0]  rq_resp [$];
  logic [1:0]  bq_resp [$];

  axi4_lite_sram_slave_if #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32)
  ) bus ();

  axi4_lite_sram_slave #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .BASE_ADDR (32'h8000_0000),
    .DEPTH_LOG2(10),
    .RD_LATENCY(RDL)
  ) dut (
    .iClock(clk),
    .iReset(rst_n),
    .s_axi (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.pAXI4S_r_valid &&
        bus.pAXI4S_r_ready) begin
      if (rq_data.size() == 0) begin
        chk("r_unexpected", 32'd1, 32'd0);
      end else begin
        chk("r_data", bus.pAXI4S_r_bits_data,
            rq_data.pop_front());
        chk("r_resp", 32'(bus.pAXI4S_r_bits_resp),
            32'(rq_resp.pop_front()));
      end
    end
    if (rst_n && bus.pAXI4S_b_valid &&
        bus.pAXI4S_b_ready) begin
      if (bq_resp.size() == 0) begin
        chk("b_unexpected", 32'd1, 32'd0);
      end else begin
        chk("b_resp", 32'(bus.pAXI4S_b_bits_resp),
            32'(bq_resp.pop_front()));
      end
    end
  end

  task automatic write_txn(input logic [31:0] a,
                           input logic [31:0] d,
                           input logic [3:0]  s,
                           input int          w_lead,
                           input logic [1:0]  er);
    bit aw_done = 0;
    bit w_done = 0;
    bit hs_aw, hs_w;
    int cyc = 0;
    bq_resp.push_back(er);
    bus.pAXI4S_aw_bits_addr = a;
    bus.pAXI4S_w_bits_data  = d;
    bus.pAXI4S_w_bits_strb  = s;
    while (!(aw_done && w_done)) begin
      bus.pAXI4S_aw_valid = !aw_done && (cyc >= w_lead);
      bus.pAXI4S_w_valid  = !w_done;
      @(negedge clk);
      hs_aw = bus.pAXI4S_aw_valid && bus.pAXI4S_aw_ready;
      hs_w  = bus.pAXI4S_w_valid && bus.pAXI4S_w_ready;
      @(posedge clk); #1;
      if (hs_aw) aw_done = 1;
      if (hs_w) w_done = 1;
      cyc++;
      if (cyc > 50) begin
        chk("write_timeout", 32'd1, 32'd0);
        break;
      end
    end
    bus.pAXI4S_aw_valid = 1'b0;
    bus.pAXI4S_w_valid  = 1'b0;
    @(negedge clk);
    chk("b_valid_latency", 32'(bus.pAXI4S_b_valid), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic read_txn(input logic [31:0] a,
                          input logic [31:0] ed,
                          input logic [1:0]  er);
    bit hs;
    int cyc = 0;
    rq_data.push_back(ed);
    rq_resp.push_back(er);
    bus.pAXI4S_ar_bits_addr = a;
    bus.pAXI4S_ar_valid = 1'b1;
    forever begin
      @(negedge clk);
      hs = bus.pAXI4S_ar_ready;
      @(posedge clk); #1;
      cyc++;
      if (hs) break;
      if (cyc > 50) begin
        chk("read_timeout", 32'd1, 32'd0);
        break;
      end
    end
    bus.pAXI4S_ar_valid = 1'b0;
    for (int k = 1; k <= RDL; k++) begin
      @(negedge clk);
      chk("r_valid_latency", 32'(bus.pAXI4S_r_valid),
          (k == RDL) ? 32'd1 : 32'd0);
      if (k == 1)
        chk("ar_ready_drop", 32'(bus.pAXI4S_ar_ready), 32'd0);
      @(posedge clk); #1;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ar_ready"}, 32'(bus.pAXI4S_ar_ready), 32'd1);
    chk({tag, "_aw_ready"}, 32'(bus.pAXI4S_aw_ready), 32'd1);
    chk({tag, "_w_ready"}, 32'(bus.pAXI4S_w_ready), 32'd1);
    chk({tag, "_r_valid"}, 32'(bus.pAXI4S_r_valid), 32'd0);
    chk({tag, "_b_valid"}, 32'(bus.pAXI4S_b_valid), 32'd0);
    chk({tag, "_r_data"}, bus.pAXI4S_r_bits_data, 32'd0);
    chk({tag, "_r_resp"}, 32'(bus.pAXI4S_r_bits_resp), 32'd0);
    chk({tag, "_b_resp"}, 32'(bus.pAXI4S_b_bits_resp), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.pAXI4S_ar_valid     = 1'b0;
    bus.pAXI4S_ar_bits_addr = '0;
    bus.pAXI4S_r_ready      = 1'b1;
    bus.pAXI4S_aw_valid     = 1'b0;
    bus.pAXI4S_aw_bits_addr = '0;
    bus.pAXI4S_w_valid      = 1'b0;
    bus.pAXI4S_w_bits_data  = '0;
    bus.pAXI4S_w_bits_strb  = '0;
    bus.pAXI4S_b_ready      = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;

    write_txn(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, 2'b00);
    read_txn(32'h8000_0010, 32'hDEAD_BEEF, 2'b00);
    write_txn(32'h8000_0010, 32'h1122_3344, 4'b0101, 2, 2'b00);
    read_txn(32'h8000_0010, 32'hDE22_BE44, 2'b00);

    write_txn(32'h8000_0000, 32'h0123_4567, 4'hF, 0, 2'b00);
    write_txn(32'h8000_0FFC, 32'hCAFE_F00D, 4'hF, 1, 2'b00);
    read_txn(32'h8000_0FFC, 32'hCAFE_F00D, 2'b00);
    read_txn(32'h7FFF_FFFC, 32'h0000_0000, 2'b10);
    write_txn(32'h8000_1000, 32'hFFFF_FFFF, 4'hF, 0, 2'b10);
    read_txn(32'h8000_0000, 32'h0123_4567, 2'b00);
    write_txn(32'h8000_0010, 32'hFFFF_FFFF, 4'h0, 0, 2'b00);
    read_txn(32'h8000_0010, 32'hDE22_BE44, 2'b00);

    bus.pAXI4S_r_ready = 1'b0;
    read_txn(32'h8000_0010, 32'hDE22_BE44, 2'b00);
    repeat (5) begin
      @(negedge clk);
      chk("stall_r_valid", 32'(bus.pAXI4S_r_valid), 32'd1);
      chk("stall_r_data", bus.pAXI4S_r_bits_data,
          32'hDE22_BE44);
      chk("stall_r_resp", 32'(bus.pAXI4S_r_bits_resp), 32'd0);
      chk("stall_ar_ready", 32'(bus.pAXI4S_ar_ready), 32'd0);
      @(posedge clk); #1;
    end
    bus.pAXI4S_r_ready = 1'b1;
    @(posedge clk); #1;

    bus.pAXI4S_b_ready = 1'b0;
    write_txn(32'h8000_2000, 32'h55AA_55AA, 4'hF, 0, 2'b10);
    repeat (5) begin
      @(negedge clk);
      chk("stall_b_valid", 32'(bus.pAXI4S_b_valid), 32'd1);
      chk("stall_b_resp", 32'(bus.pAXI4S_b_bits_resp), 32'd2);
      chk("stall_aw_ready", 32'(bus.pAXI4S_aw_ready), 32'd0);
      chk("stall_w_ready", 32'(bus.pAXI4S_w_ready), 32'd0);
      @(posedge clk); #1;
    end
    bus.pAXI4S_b_ready = 1'b1;
    @(posedge clk); #1;

    write_txn(32'h8000_0020, 32'hAAAA_5555, 4'hF, 0, 2'b00);
    fork
      read_txn(32'h8000_0020, 32'hAAAA_5555, 2'b00);
      begin
        repeat (RDL - 1) begin
          @(posedge clk); #1;
        end
        write_txn(32'h8000_0020, 32'h1234_5678, 4'hF, 0,
                  2'b00);
      end
    join
    read_txn(32'h8000_0020, 32'h1234_5678, 2'b00);

    write_txn(32'h8000_0030, 32'h0BAD_F00D, 4'hF, 0, 2'b00);
    bus.pAXI4S_ar_bits_addr = 32'h8000_0030;
    bus.pAXI4S_aw_bits_addr = 32'h8000_0030;
    bus.pAXI4S_w_bits_data  = 32'hFFFF_FFFF;
    bus.pAXI4S_w_bits_strb  = 4'hF;
    bus.pAXI4S_ar_valid = 1'b1;
    bus.pAXI4S_aw_valid = 1'b1;
    @(posedge clk); #1;
    bus.pAXI4S_ar_valid = 1'b0;
    bus.pAXI4S_aw_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_ar_ready", 32'(bus.pAXI4S_ar_ready), 32'd0);
    chk("mid_aw_ready", 32'(bus.pAXI4S_aw_ready), 32'd0);
    chk("mid_w_ready", 32'(bus.pAXI4S_w_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_vals("midrst");
    @(posedge clk); #1;
    write_txn(32'h8000_0034, 32'h7777_8888, 4'hF, 0, 2'b00);
    read_txn(32'h8000_0030, 32'h0BAD_F00D, 2'b00);
    read_txn(32'h8000_0034, 32'h7777_8888, 2'b00);

    repeat (4) @(posedge clk);
    chk("rq_drained", 32'(rq_data.size()), 32'd0);
    chk("bq_drained", 32'(bq_resp.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end
endmodule
